// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, per-bit oversampling counter,
// 2-of-3 majority vote around mid-bit, optional parity, single-cycle status pulses.
module uart_rx #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_in,
   input  logic                  parity_enable,
   input  logic                  parity_type,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  parity_error,
   output logic                  framing_error
);

   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                state_q, state_d;
   logic                  meta_q, rx_s_q;
   logic [PRESCALE_W-1:0] cnt_q, cnt_d;
   logic [PRESCALE_W-1:0] pre_q, pre_d;
   logic                  pen_q, pen_d;
   logic                  ptype_q, ptype_d;
   logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [1:0]            smp_q, smp_d;
   logic                  vote_q, vote_d;
   logic                  perr_q, perr_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  dv_q, dv_d;
   logic                  pe_q, pe_d;
   logic                  fe_q, fe_d;

   logic [PRESCALE_W-1:0] half, s_lo, s_hi, s_end, last;
   logic                  maj;
   logic                  rx_s;

   assign rx_s  = rx_s_q;
   assign half  = pre_q >> 1;
   assign s_lo  = half - PRESCALE_W'(1);
   assign s_hi  = half + PRESCALE_W'(1);
   assign s_end = half + PRESCALE_W'(2);
   assign last  = pre_q - PRESCALE_W'(1);
   // Third sample is taken live at s_hi, so the vote is ready on that cycle.
   assign maj   = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pre_d     = pre_q;
      pen_d     = pen_q;
      ptype_d   = ptype_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      smp_d     = smp_q;
      vote_d    = vote_q;
      perr_d    = perr_q;
      dout_d    = dout_q;
      dv_d      = 1'b0;
      pe_d      = 1'b0;
      fe_d      = 1'b0;

      if (state_q != IDLE) begin
         cnt_d = (cnt_q == last) ? '0 : cnt_q + PRESCALE_W'(1);
         if (cnt_q == s_lo) smp_d[0] = rx_s;
         if (cnt_q == half) smp_d[1] = rx_s;
      end

      unique case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d   = START;
               cnt_d     = '0;
               pre_d     = prescale;
               pen_d     = parity_enable;
               ptype_d   = parity_type;
               bit_idx_d = '0;
               perr_d    = 1'b0;
            end
         end
         START: begin
            if (cnt_q == s_hi) vote_d = maj;
            if (cnt_q == s_end && vote_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == last) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (cnt_q == s_hi) shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
            if (cnt_q == last) begin
               if (bit_idx_q == BIT_W'(DATA_WIDTH-1))
                  state_d = pen_q ? PARITY : STOP;
               else
                  bit_idx_d = bit_idx_q + BIT_W'(1);
            end
         end
         PARITY: begin
            if (cnt_q == s_hi) perr_d = maj ^ (^shift_q) ^ ptype_q;
            if (cnt_q == last) state_d = STOP;
         end
         STOP: begin
            if (cnt_q == s_hi) vote_d = maj;
            if (cnt_q == last) begin
               state_d = IDLE;
               // Framing error masks a parity error on the same frame.
               if (!vote_q)     fe_d = 1'b1;
               else if (perr_q) pe_d = 1'b1;
               else begin
                  dv_d   = 1'b1;
                  dout_d = shift_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         meta_q    <= 1'b1;
         rx_s_q    <= 1'b1;
         cnt_q     <= '0;
         pre_q     <= '0;
         pen_q     <= 1'b0;
         ptype_q   <= 1'b0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         smp_q     <= '0;
         vote_q    <= 1'b0;
         perr_q    <= 1'b0;
         dout_q    <= '0;
         dv_q      <= 1'b0;
         pe_q      <= 1'b0;
         fe_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         meta_q    <= rx_in;
         rx_s_q    <= meta_q;
         cnt_q     <= cnt_d;
         pre_q     <= pre_d;
         pen_q     <= pen_d;
         ptype_q   <= ptype_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         smp_q     <= smp_d;
         vote_q    <= vote_d;
         perr_q    <= perr_d;
         dout_q    <= dout_d;
         dv_q      <= dv_d;
         pe_q      <= pe_d;
         fe_q      <= fe_d;
      end
   end

   assign data_out      = dout_q;
   assign data_valid    = dv_q;
   assign parity_error  = pe_q;
   assign framing_error = fe_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving payload bits per frame.
REQ-002 SHALL have parameter PRESCALE_W, default 6, giving the prescale input width (holds 32).
REQ-003 SHALL have port clk  input  1  rx oversampling clock at prescale x baud; the block's only clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rx_in  input  1  serial line, asynchronous, idle high.
REQ-006 SHALL have port parity_enable  input  1  1 = frame carries a parity bit.
REQ-007 SHALL have port parity_type  input  1  0 = even, 1 = odd.
REQ-008 SHALL have port prescale  input  PRESCALE_W  oversamples per bit; legal values even, 8..32.
REQ-009 SHALL have port data_out  output  DATA_WIDTH  last good payload.
REQ-010 SHALL have port data_valid  output  1  one-cycle pulse, data_out updated.
REQ-011 SHALL have port parity_error  output  1  one-cycle pulse, parity mismatch.
REQ-012 SHALL have port framing_error  output  1  one-cycle pulse, stop bit sampled 0.

Function
REQ-013 SHALL pass rx_in through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
REQ-014 SHALL latch parity_enable, parity_type and prescale when a start bit is detected; changes mid-frame SHALL be ignored until the next frame.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE -> START on rx_s == 0; edge counter cleared to 0 on entry.
REQ-017 Edge counter SHALL count 0..prescale-1 per bit, wrapping to 0 at prescale-1 and advancing the bit.
REQ-018 Each bit value SHALL be the 2-of-3 majority of rx_s at edge counts prescale/2-1, prescale/2, prescale/2+1.
REQ-019 START: if majority == 1 (glitch), return to IDLE at edge count prescale/2+2 with no output pulse; else -> DATA at bit end.
REQ-020 DATA: shift DATA_WIDTH bits LSB first; after the last bit -> PARITY if latched parity_enable, else -> STOP.
REQ-021 PARITY: expected bit = XOR of payload XOR parity_type; mismatch sets an internal parity flag; -> STOP at bit end.
REQ-022 STOP: at edge count prescale-1 -> IDLE; in the next cycle exactly one of data_valid, parity_error, framing_error SHALL pulse high.
REQ-023 Priority when both errors occur: framing_error pulses, parity_error does not.
REQ-024 data_out SHALL update only with data_valid and otherwise hold its value.
REQ-025 A start bit immediately following the stop bit SHALL be detected from IDLE with no lost frame.
REQ-026 Illegal prescale behaviour is undefined; no protection is required.

Reset
REQ-027 With rst_n low at a rising clk edge: FSM -> IDLE, counters 0, synchronizer flops 1, data_out 0, data_valid/parity_error/framing_error 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no output pulse; reception resumes on the next falling edge after rst_n is high.

Verification
REQ-029 prescale=8, parity on/even, frame 0xA5 with parity bit 0, stop 1 -> data_valid pulse, data_out=0xA5, no errors.
REQ-030 prescale=16, parity on/odd, 0x3C sent with parity bit 0 -> parity_error pulse, no data_valid, data_out unchanged.
REQ-031 prescale=8, parity off, 0x00 with stop bit 0 -> framing_error pulse only; 0xFF sent next back-to-back -> data_valid, data_out=0xFF.
REQ-032 prescale=8, 2-cycle low glitch on rx_in -> FSM returns to IDLE, no output pulses.
REQ-033 prescale=32, rst_n low for 1 cycle during DATA bit 4 of 0x55 -> no pulse; next frame 0x81 -> data_valid, data_out=0x81.
REQ-034 prescale=8, single-sample inverted spike at edge count 4 of each data bit of 0x5A -> majority vote recovers data_out=0x5A.
